axi_llc_flush_ctrl: RTL and testbench
=====================================

# axi_llc_flush_ctrl

RegBus initiator that drives the LLC configuration port to flush a selected set of ways and reports completion. It sits between a system-level control source (power manager, boot sequencer, DMA engine) and the `conf_req`/`conf_resp` port of `axi_llc_reg_wrap`. It issues the flush-mask write and the commit write, then polls the flush register until the LLC clears it, an error response arrives, or a poll limit is reached.

## Interface
- `SetAssociativity`, default 8: width of the way mask; must be 1..32.
- `CfgBaseAddr`, default 32'h0: base address of the LLC configuration register file.
- `FlushOffset`, default 32'h08: byte offset of the flush register (mask write and poll read).
- `CommitOffset`, default 32'h10: byte offset of the commit register.
- `PollInterval`, default 16: idle cycles between two poll reads; must be ≥ 1.
- `MaxPolls`, default 1024: poll reads before timeout; must be ≥ 1.
- `clk_i` in 1: rising-edge clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `flush_valid_i` in 1: flush command valid.
- `flush_ready_o` out 1: command accepted when `flush_valid_i && flush_ready_o`.
- `flush_ways_i` in SetAssociativity: ways to flush, sampled at acceptance.
- `busy_o` out 1: flush sequence in progress.
- `done_o` out 1: one-cycle pulse at the end of a sequence.
- `error_o` out 1: with `done_o`, the sequence ended in a bus error or a timeout.
- `timeout_o` out 1: with `done_o`, the sequence ended in a timeout.
- `conf_req_addr_o` out 32, `conf_req_w_o` out 1, `conf_req_wdata_o` out 32, `conf_req_wstrb_o` out 4, `conf_req_valid_o` out 1: RegBus request.
- `conf_resp_rdata_i` in 32, `conf_resp_error_i` in 1, `conf_resp_ready_i` in 1: RegBus response.

## Operation
- States: IDLE, WR_MASK, WR_COMMIT, WAIT, RD_POLL, FINISH.
- IDLE: `flush_ready_o`=1. On acceptance, latch the mask.
  - Mask nonzero: go to WR_MASK.
  - Mask zero: go to FINISH with no bus access and no error.
- WR_MASK: write at `CfgBaseAddr+FlushOffset`, wdata = mask zero-extended to 32 bits, wstrb=4'hF.
- WR_COMMIT: write 32'h1 at `CfgBaseAddr+CommitOffset`, wstrb=4'hF.
- WAIT: count `PollInterval` cycles, then go to RD_POLL.
- RD_POLL: read at `CfgBaseAddr+FlushOffset` with w=0 and wstrb=0. Increment the poll counter when the read completes.
  - `(rdata & mask)==0`: go to FINISH with success.
  - Otherwise, poll counter == `MaxPolls`: go to FINISH with timeout.
  - Otherwise: go to WAIT.
- Any completed access with `conf_resp_error_i`=1: go to FINISH with error. The remaining accesses are skipped.
- FINISH: pulse `done_o` for one cycle, drive `error_o`/`timeout_o` for that cycle only, then return to IDLE.
- RegBus handshake: `conf_req_valid_o` stays high, with addr, w, wdata and wstrb held stable, until the cycle in which `conf_resp_ready_i`=1. That cycle completes the access, and rdata/error are sampled in it. The block never withdraws a request.
- `busy_o` = state is not IDLE (FINISH included). Commands arriving while busy are not accepted.
- Address adds wrap modulo 2^32.
- Poll counter width is $clog2(MaxPolls+1). It is cleared on acceptance.

## Timing
- Reset values: `flush_ready_o`=1; `busy_o`, `done_o`, `error_o`, `timeout_o`, `conf_req_valid_o`, `conf_req_w_o`=0; addr, wdata and wstrb=0. State is IDLE and all counters are 0.
- Acceptance in cycle 0 gives `conf_req_valid_o`=1 in cycle 1 (WR_MASK).
- The next request is issued in the cycle after the previous access completes. There is no bubble between WR_MASK and WR_COMMIT.
- WAIT lasts exactly `PollInterval` cycles. A read is issued in the cycle after WAIT ends.
- `done_o` is asserted in the cycle after the final access completes. For a zero mask, `done_o` is asserted in cycle 1.
- Back-to-back commands: the next acceptance is possible in the cycle after `done_o`.
- With a zero-wait slave and a first poll that reads clear, the minimum sequence is accept at cycle 0, writes in cycles 1 and 2, WAIT in cycles 3..2+PollInterval, read in cycle 3+PollInterval, and `done_o` in cycle 4+PollInterval.
- Reset asserted mid-sequence: all outputs return to reset values immediately and asynchronously. An outstanding RegBus request is dropped and no `done_o` is generated.

## Test plan
- Mask 8'h0F, zero-wait slave, first poll reads 0: write 32'h0F at 0x08, then write 32'h1 at 0x10, then one read at 0x08. `done_o` at cycle 20 with `PollInterval`=16, and `error_o`=0.
- Slave holds ready low for 5 cycles on each access: request fields stay stable while valid is high. Each access completes exactly once, and the total latency grows by 15 cycles.
- Polls return 32'h0F, 32'h03, then 32'h00: exactly three reads, spaced `PollInterval` idle cycles apart, then the `done_o` pulse. Also check that rdata bits outside the mask (e.g. 32'hF0) count as clear.
- Error response on WR_COMMIT: no poll read is issued, and `done_o`=1 with `error_o`=1 and `timeout_o`=0 in the next cycle.
- `MaxPolls`=4 and every poll returns the mask: exactly 4 reads, then `done_o`=1 with `error_o`=1 and `timeout_o`=1. A zero mask gives `done_o` in cycle 1 with no request.
- `rst_ni` dropped while WAIT is in progress: all outputs go low immediately and `flush_ready_o`=1. After reset, a new command runs a full, correct sequence.

Source files
------------

// File: rtl/axi_llc_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_flush_ctrl
// Description : RegBus initiator that flushes a selected set of LLC ways.
//               It writes the flush mask, commits it, then polls the flush
//               register until the selected ways read clear, a bus error
//               occurs, or the poll budget runs out.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_flush_ctrl #(
    parameter int unsigned SetAssociativity = 8,
    parameter logic [31:0] CfgBaseAddr      = 32'h0,
    parameter logic [31:0] FlushOffset      = 32'h08,
    parameter logic [31:0] CommitOffset     = 32'h10,
    parameter int unsigned PollInterval     = 16,
    parameter int unsigned MaxPolls         = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_valid_i,
    output logic                        flush_ready_o,
    input  logic [SetAssociativity-1:0] flush_ways_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        timeout_o,
    output logic [31:0]                 conf_req_addr_o,
    output logic                        conf_req_w_o,
    output logic [31:0]                 conf_req_wdata_o,
    output logic [3:0]                  conf_req_wstrb_o,
    output logic                        conf_req_valid_o,
    input  logic [31:0]                 conf_resp_rdata_i,
    input  logic                        conf_resp_error_i,
    input  logic                        conf_resp_ready_i
);

    localparam int unsigned c_POLL_W = $clog2(MaxPolls + 1);
    localparam int unsigned c_WAIT_W = $clog2(PollInterval + 1);

    // Register addresses; 32-bit arithmetic wraps naturally.
    localparam logic [31:0] c_FLUSH_ADDR  = CfgBaseAddr + FlushOffset;
    localparam logic [31:0] c_COMMIT_ADDR = CfgBaseAddr + CommitOffset;

    localparam logic [c_POLL_W-1:0] c_MAX_POLLS = c_POLL_W'(MaxPolls);
    localparam logic [c_POLL_W-1:0] c_POLL_ONE  = c_POLL_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(PollInterval - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WR_MASK   = 3'd1;
    localparam logic [2:0] c_WR_COMMIT = 3'd2;
    localparam logic [2:0] c_WAIT      = 3'd3;
    localparam logic [2:0] c_RD_POLL   = 3'd4;
    localparam logic [2:0] c_FINISH    = 3'd5;

    logic [2:0]                  r_state;
    logic [SetAssociativity-1:0] r_mask;
    logic [c_POLL_W-1:0]         r_poll_cnt;
    logic [c_WAIT_W-1:0]         r_wait_cnt;
    logic                        r_err;
    logic                        r_timeout;

    logic [31:0]         w_mask_32;
    logic [c_POLL_W-1:0] w_poll_next;
    logic                w_poll_clear;

    assign w_mask_32    = 32'(r_mask);
    assign w_poll_next  = r_poll_cnt + c_POLL_ONE;
    // Bits outside the selected ways are ignored when judging completion.
    assign w_poll_clear = ((conf_resp_rdata_i & w_mask_32) == 32'h0);

    // Sequence control: access completion is only acted on in a ready cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= c_IDLE;
            r_mask     <= '0;
            r_poll_cnt <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush_valid_i) begin
                        r_mask     <= flush_ways_i;
                        r_poll_cnt <= '0;
                        r_wait_cnt <= '0;
                        r_err      <= 1'b0;
                        r_timeout  <= 1'b0;
                        // An empty mask needs no bus traffic at all.
                        r_state    <= (flush_ways_i != '0) ? c_WR_MASK : c_FINISH;
                    end
                end
                c_WR_MASK: begin
                    if (conf_resp_ready_i) begin
                        if (conf_resp_error_i) begin
                            r_err   <= 1'b1;
                            r_state <= c_FINISH;
                        end else begin
                            r_state <= c_WR_COMMIT;
                        end
                    end
                end
                c_WR_COMMIT: begin
                    if (conf_resp_ready_i) begin
                        if (conf_resp_error_i) begin
                            r_err   <= 1'b1;
                            r_state <= c_FINISH;
                        end else begin
                            r_wait_cnt <= '0;
                            r_state    <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= c_RD_POLL;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                end
                c_RD_POLL: begin
                    if (conf_resp_ready_i) begin
                        r_poll_cnt <= w_poll_next;
                        if (conf_resp_error_i) begin
                            r_err   <= 1'b1;
                            r_state <= c_FINISH;
                        end else if (w_poll_clear) begin
                            r_state <= c_FINISH;
                        end else if (w_poll_next == c_MAX_POLLS) begin
                            r_err     <= 1'b1;
                            r_timeout <= 1'b1;
                            r_state   <= c_FINISH;
                        end else begin
                            r_wait_cnt <= '0;
                            r_state    <= c_WAIT;
                        end
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        flush_ready_o    = (r_state == c_IDLE);
        busy_o           = (r_state != c_IDLE);
        done_o           = (r_state == c_FINISH);
        error_o          = (r_state == c_FINISH) && r_err;
        timeout_o        = (r_state == c_FINISH) && r_timeout;
        conf_req_valid_o = 1'b0;
        conf_req_addr_o  = 32'h0;
        conf_req_w_o     = 1'b0;
        conf_req_wdata_o = 32'h0;
        conf_req_wstrb_o = 4'h0;
        case (r_state)
            c_WR_MASK: begin
                conf_req_valid_o = 1'b1;
                conf_req_addr_o  = c_FLUSH_ADDR;
                conf_req_w_o     = 1'b1;
                conf_req_wdata_o = w_mask_32;
                conf_req_wstrb_o = 4'hF;
            end
            c_WR_COMMIT: begin
                conf_req_valid_o = 1'b1;
                conf_req_addr_o  = c_COMMIT_ADDR;
                conf_req_w_o     = 1'b1;
                conf_req_wdata_o = 32'h1;
                conf_req_wstrb_o = 4'hF;
            end
            c_RD_POLL: begin
                conf_req_valid_o = 1'b1;
                conf_req_addr_o  = c_FLUSH_ADDR;
            end
            default: begin
                conf_req_valid_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_flush_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_llc_flush_ctrl
// Description : Self-checking bench for axi_llc_flush_ctrl with a RegBus
//               slave model and an access/completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_llc_flush_ctrl;

    localparam int c_SA = 8;
    localparam int c_PI = 16;
    localparam int c_MP = 4;
    localparam logic [31:0] c_FLUSH  = 32'h08;
    localparam logic [31:0] c_COMMIT = 32'h10;

    typedef struct packed {
        logic [31:0] addr;
        logic        w;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    typedef struct {
        bit err;
        bit to;
        int cyc;
    } done_t;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_valid_i;
    logic            flush_ready_o;
    logic [c_SA-1:0] flush_ways_i;
    logic            busy_o, done_o, error_o, timeout_o;
    logic [31:0]     conf_req_addr_o, conf_req_wdata_o;
    logic            conf_req_w_o, conf_req_valid_o;
    logic [3:0]      conf_req_wstrb_o;
    logic [31:0]     conf_resp_rdata_i;
    logic            conf_resp_error_i, conf_resp_ready_i;

    axi_llc_flush_ctrl #(
        .SetAssociativity (c_SA),
        .CfgBaseAddr      (32'h0),
        .FlushOffset      (c_FLUSH),
        .CommitOffset     (c_COMMIT),
        .PollInterval     (c_PI),
        .MaxPolls         (c_MP)
    ) u_dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_valid_i     (flush_valid_i),
        .flush_ready_o     (flush_ready_o),
        .flush_ways_i      (flush_ways_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .error_o           (error_o),
        .timeout_o         (timeout_o),
        .conf_req_addr_o   (conf_req_addr_o),
        .conf_req_w_o      (conf_req_w_o),
        .conf_req_wdata_o  (conf_req_wdata_o),
        .conf_req_wstrb_o  (conf_req_wstrb_o),
        .conf_req_valid_o  (conf_req_valid_o),
        .conf_resp_rdata_i (conf_resp_rdata_i),
        .conf_resp_error_i (conf_resp_error_i),
        .conf_resp_ready_i (conf_resp_ready_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    acc_t        exp_acc[$];
    logic [31:0] rd_q[$];
    done_t       exp_done[$];

    int   slave_wait  = 0;
    int   err_at      = -1;
    int   acc_idx     = 0;
    int   wcnt        = 0;
    int   rd_cnt      = 0;
    int   last_rd_cyc = -1;
    int   done_cnt    = 0;
    int   start_done  = 0;
    acc_t cap;
    acc_t e_acc;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    // RegBus slave: optional wait states, scripted read data, error injection.
    always @(negedge clk) begin
        if (!rst_ni) begin
            conf_resp_ready_i = 1'b0;
            conf_resp_error_i = 1'b0;
            conf_resp_rdata_i = 32'h0;
            wcnt = 0;
        end else if (conf_req_valid_o) begin
            if (wcnt == 0) begin
                cap = {conf_req_addr_o, conf_req_w_o, conf_req_wdata_o, conf_req_wstrb_o};
            end else begin
                check("hold_addr_data", {conf_req_addr_o, conf_req_wdata_o}, {cap.addr, cap.wdata});
                check("hold_w_strb", {conf_req_w_o, conf_req_wstrb_o}, {cap.w, cap.wstrb});
            end
            if (wcnt < slave_wait) begin
                conf_resp_ready_i = 1'b0;
                conf_resp_error_i = 1'b1;
                conf_resp_rdata_i = 32'hDEAD_BEEF;
                wcnt++;
            end else begin
                wcnt = 0;
                conf_resp_ready_i = 1'b1;
                conf_resp_error_i = (acc_idx == err_at);
                conf_resp_rdata_i = 32'h0;
                if (exp_acc.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    e_acc = exp_acc.pop_front();
                    check("acc_addr_data", {conf_req_addr_o, conf_req_wdata_o}, {e_acc.addr, e_acc.wdata});
                    check("acc_w_strb", {conf_req_w_o, conf_req_wstrb_o}, {e_acc.w, e_acc.wstrb});
                end
                if (!conf_req_w_o) begin
                    if (rd_q.size() > 0) conf_resp_rdata_i = rd_q.pop_front();
                    if (last_rd_cyc >= 0) check("poll_spacing", cyc - last_rd_cyc, c_PI + 1);
                    last_rd_cyc = cyc;
                    rd_cnt++;
                end
                acc_idx++;
            end
        end else begin
            conf_resp_ready_i = 1'b0;
            conf_resp_error_i = 1'b0;
            conf_resp_rdata_i = 32'h0;
        end
    end

    // Completion scoreboard.
    always @(negedge clk) begin
        done_t d;
        if (rst_ni && done_o) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                d = exp_done.pop_front();
                check("done_error", error_o, d.err);
                check("done_timeout", timeout_o, d.to);
                if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
            end
        end
    end

    task automatic push_seq(input logic [c_SA-1:0] ways, input bit with_commit, input int n_rd);
        exp_acc.push_back({c_FLUSH, 1'b1, 32'(ways), 4'hF});
        if (with_commit) exp_acc.push_back({c_COMMIT, 1'b1, 32'h1, 4'hF});
        for (int i = 0; i < n_rd; i++) exp_acc.push_back({c_FLUSH, 1'b0, 32'h0, 4'h0});
    endtask

    task automatic start_cmd(input logic [c_SA-1:0] ways, input bit e, input bit t, input int lat);
        done_t d;
        int    b;
        @(negedge clk);
        b = 0;
        while (!flush_ready_o && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("ready_before_cmd", flush_ready_o, 1);
        start_done    = done_cnt;
        acc_idx       = 0;
        rd_cnt        = 0;
        last_rd_cyc   = -1;
        flush_valid_i = 1'b1;
        flush_ways_i  = ways;
        d.err = e;
        d.to  = t;
        d.cyc = cyc + lat;
        exp_done.push_back(d);
        @(negedge clk);
        flush_valid_i = 1'b0;
        flush_ways_i  = '0;
    endtask

    task automatic wait_done(input int n_rd);
        int b;
        b = 0;
        while (done_cnt == start_done && b < 500) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("done_seen", done_cnt != start_done, 1);
        @(negedge clk);
        #1;
        check("done_one_cycle", done_o, 0);
        check("ready_after_done", flush_ready_o, 1);
        check("reads_issued", rd_cnt, n_rd);
        check("accesses_left", exp_acc.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni        = 1'b0;
        flush_valid_i = 1'b0;
        flush_ways_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", flush_ready_o, 1);
        check("rst_flags", {busy_o, done_o, error_o, timeout_o}, 4'b0000);
        check("rst_req_ctl", {conf_req_valid_o, conf_req_w_o, conf_req_wstrb_o}, 6'h0);
        check("rst_req_addr_data", {conf_req_addr_o, conf_req_wdata_o}, 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Basic flush: zero-wait slave, first poll reads clear.
        push_seq(8'h0F, 1'b1, 1);
        rd_q.push_back(32'h0);
        start_cmd(8'h0F, 1'b0, 1'b0, 4 + c_PI);
        wait_done(1);

        // Slave stalls five cycles on every access.
        slave_wait = 5;
        push_seq(8'hA5, 1'b1, 1);
        rd_q.push_back(32'h0);
        start_cmd(8'hA5, 1'b0, 1'b0, 4 + c_PI + 15);
        wait_done(1);
        slave_wait = 0;

        // Three polls before the selected ways read clear.
        push_seq(8'h0F, 1'b1, 3);
        rd_q.push_back(32'h0F);
        rd_q.push_back(32'h03);
        rd_q.push_back(32'h00);
        start_cmd(8'h0F, 1'b0, 1'b0, 4 + c_PI + 2 * (c_PI + 1));
        wait_done(3);

        // Set bits outside the mask count as clear.
        push_seq(8'h0F, 1'b1, 1);
        rd_q.push_back(32'hFFFF_FFF0);
        start_cmd(8'h0F, 1'b0, 1'b0, 4 + c_PI);
        wait_done(1);

        // Error on the commit write skips polling.
        err_at = 1;
        push_seq(8'h81, 1'b1, 0);
        start_cmd(8'h81, 1'b1, 1'b0, 3);
        wait_done(0);

        // Error on the mask write skips the commit too.
        err_at = 0;
        push_seq(8'h01, 1'b0, 0);
        start_cmd(8'h01, 1'b1, 1'b0, 2);
        wait_done(0);
        err_at = -1;

        // Poll budget exhausted.
        push_seq(8'hFF, 1'b1, c_MP);
        for (int i = 0; i < c_MP; i++) rd_q.push_back(32'hFF);
        start_cmd(8'hFF, 1'b1, 1'b1, 4 + c_PI + (c_MP - 1) * (c_PI + 1));
        wait_done(c_MP);

        // Empty mask completes with no bus traffic.
        start_cmd(8'h00, 1'b0, 1'b0, 1);
        wait_done(0);

        // Reset while waiting between commit and poll.
        push_seq(8'h3C, 1'b1, 1);
        rd_q.push_back(32'h0);
        start_cmd(8'h3C, 1'b0, 1'b0, 4 + c_PI);
        repeat (6) @(negedge clk);
        #1;
        check("busy_in_wait", busy_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_flags", {busy_o, done_o, error_o, timeout_o}, 4'b0000);
        check("arst_ready", flush_ready_o, 1);
        check("arst_req_ctl", {conf_req_valid_o, conf_req_w_o, conf_req_wstrb_o}, 6'h0);
        exp_acc.delete();
        rd_q.delete();
        exp_done.delete();
        start_done = done_cnt;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("no_done_after_reset", done_cnt, start_done);

        // Full sequence after reset.
        push_seq(8'h3C, 1'b1, 2);
        rd_q.push_back(32'h04);
        rd_q.push_back(32'hC3);
        start_cmd(8'h3C, 1'b0, 1'b0, 4 + c_PI + (c_PI + 1));
        wait_done(2);

        check("done_left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
